// File: rtl/digest_target_checker.sv
// digest_target_checker: reads an 8-word SHA-256 digest back from a
// synchronous memory, assembles it MSW first and compares it against a
// 256-bit target. Digest and hit flag go to the consumer over valid/ready.
module digest_target_checker #(
  parameter bit REVERSE_BYTES = 1'b0,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] digest_addr,
  input  logic [255:0]      target,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [255:0]      digest,
  output logic              hit
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_READ   = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  // Cycle counter since start acceptance: value k-1 seen at edge Ek.
  // Addresses base+1..base+7 issue while it reads 0..6, words are
  // captured while it reads 1..8.
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [223:0]        r_shift;
  logic                r_busy;
  logic                r_valid;
  logic [255:0]        r_digest;
  logic                r_hit;

  logic                w_accept;
  logic                w_issue;
  logic                w_capture;
  logic                w_done;
  logic                w_release;
  logic [2:0]          w_cap_idx;
  logic [255:0]        w_assembled;
  logic [255:0]        w_final;
  logic                w_hit_final;

  // The memory shares our clock and is never written.
  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'd0;

  assign mem_addr     = r_addr;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign digest       = r_digest;
  assign hit          = r_hit;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start)             w_state_next = S_READ;
      S_READ:   if (r_cnt == 4'd6)     w_state_next = S_DRAIN;
      S_DRAIN:  if (r_cnt == 4'd8)     w_state_next = S_RESULT;
      S_RESULT: if (result_ready)      w_state_next = S_IDLE;
      default:                         w_state_next = S_IDLE;
    endcase
  end

  // Control strobes decoded from state and counter.
  always_comb begin
    w_accept  = 1'b0;
    w_issue   = 1'b0;
    w_capture = 1'b0;
    w_done    = 1'b0;
    w_release = 1'b0;
    case (r_state)
      S_IDLE:   w_accept  = start;
      S_READ: begin
        w_issue   = 1'b1;
        w_capture = (r_cnt != 4'd0);
      end
      S_DRAIN: begin
        w_capture = 1'b1;
        w_done    = (r_cnt == 4'd8);
      end
      S_RESULT: w_release = result_ready;
      default:  ;
    endcase
  end

  assign w_cap_idx   = r_cnt[2:0] - 3'd1;
  // Word 7 arrives on the same edge that registers the result.
  assign w_assembled = {r_shift, mem_read_data};

  generate
    if (REVERSE_BYTES) begin : g_rev
      logic [255:0] w_reversed;
      genvar gi;
      for (gi = 0; gi < 32; gi++) begin : g_byte
        assign w_reversed[8*gi +: 8] = w_assembled[255-8*gi -: 8];
      end
      // Byte reversal also reverses word order, so compare the full value.
      assign w_final     = w_reversed;
      assign w_hit_final = (w_reversed < target);
    end else begin : g_fwd
      logic        r_eq_so_far;
      logic        r_lt;
      logic        w_eq_next;
      logic        w_lt_next;
      logic [31:0] w_tgt_word;
      logic [7:0]  w_tgt_lsb;

      // Target word i sits at bit offset 32*(7-i).
      assign w_tgt_lsb  = {~w_cap_idx, 5'b00000};
      assign w_tgt_word = target[w_tgt_lsb +: 32];

      // Only the first differing word decides the outcome.
      always_comb begin
        w_eq_next = r_eq_so_far;
        w_lt_next = r_lt;
        if (r_eq_so_far && (mem_read_data != w_tgt_word)) begin
          w_eq_next = 1'b0;
          w_lt_next = (mem_read_data < w_tgt_word);
        end
      end

      // Incremental MSW-first comparison state.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_eq_so_far <= 1'b1;
          r_lt        <= 1'b0;
        end else if (w_accept) begin
          r_eq_so_far <= 1'b1;
          r_lt        <= 1'b0;
        end else if (w_capture) begin
          r_eq_so_far <= w_eq_next;
          r_lt        <= w_lt_next;
        end
      end

      assign w_final     = w_assembled;
      assign w_hit_final = w_lt_next;
    end
  endgenerate

  // Datapath: address issue, word capture, result and handshake flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_shift  <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_digest <= '0;
      r_hit    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt  <= 4'd0;
        r_addr <= digest_addr;
        r_busy <= 1'b1;
      end else if (r_state == S_READ || r_state == S_DRAIN) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_issue)   r_addr  <= r_addr + ADDR_W'(1);
      if (w_capture) r_shift <= {r_shift[191:0], mem_read_data};
      if (w_done) begin
        r_digest <= w_final;
        r_hit    <= w_hit_final;
        r_valid  <= 1'b1;
      end
      if (w_release) begin
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_digest_target_checker.sv
// Directed bench for digest_target_checker: a forward instance and a
// byte-reversing instance share a one-cycle synchronous memory model.
module tb_digest_target_checker;

  localparam logic [255:0] ABC  = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] ALLF = {256{1'b1}};
  localparam logic [255:0] BP   = 256'hc0de0000_c0de0001_c0de0002_c0de0003_c0de0004_c0de0005_c0de0006_c0de0007;
  localparam logic [255:0] WRAP = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
  localparam logic [255:0] REV_MEM = 256'h0000ffff;
  localparam logic [255:0] REV_EXP = {16'hffff, 240'h0};
  localparam logic [255:0] T_2_240 = {16'h0001, 240'h0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          start0, start1;
  logic [15:0]   digest_addr;
  logic [255:0]  target;
  logic          result_ready;

  logic          mclk0, we0, busy0, rv0, hit0;
  logic [15:0]   addr0;
  logic [31:0]   wdata0, rdata0;
  logic [255:0]  dig0;
  logic          mclk1, we1, busy1, rv1, hit1;
  logic [15:0]   addr1;
  logic [31:0]   wdata1, rdata1;
  logic [255:0]  dig1;

  logic [31:0]   mem [0:65535];

  int n_checks = 0;
  int n_errors = 0;

  digest_target_checker #(.REVERSE_BYTES(1'b0), .ADDR_W(16)) u_fwd (
    .clk(clk), .reset_n(reset_n), .start(start0), .digest_addr(digest_addr),
    .target(target), .mem_clk(mclk0), .mem_we(we0), .mem_addr(addr0),
    .mem_write_data(wdata0), .mem_read_data(rdata0), .busy(busy0),
    .result_valid(rv0), .result_ready(result_ready), .digest(dig0), .hit(hit0)
  );

  digest_target_checker #(.REVERSE_BYTES(1'b1), .ADDR_W(16)) u_rev (
    .clk(clk), .reset_n(reset_n), .start(start1), .digest_addr(digest_addr),
    .target(target), .mem_clk(mclk1), .mem_we(we1), .mem_addr(addr1),
    .mem_write_data(wdata1), .mem_read_data(rdata1), .busy(busy1),
    .result_valid(rv1), .result_ready(result_ready), .digest(dig1), .hit(hit1)
  );

  // Synchronous read memory: one cycle from registered address to data.
  always @(posedge clk) begin
    rdata0 <= mem[addr0];
    rdata1 <= mem[addr1];
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load_digest(input logic [15:0] base, input logic [255:0] d);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      mem[a] = d[255-32*i -: 32];
    end
  endtask

  // Start one operation and check address issue, latency and the result.
  task automatic run_op(input bit sel, input logic [15:0] base, input logic [255:0] tgt,
                        input logic [255:0] exp_dig, input logic exp_hit, input string tag);
    @(negedge clk);
    digest_addr = base;
    target      = tgt;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
    check_val({tag, "_busy"}, sel ? busy1 : busy0, 1);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] ea;
      if (k > 0) begin
        @(posedge clk); #1;
      end
      ea = base + 16'(k);
      check_val($sformatf("%s_addr%0d", tag, k), sel ? addr1 : addr0, ea);
    end
    @(posedge clk); #1;
    check_val({tag, "_rv_e8"}, sel ? rv1 : rv0, 0);
    @(posedge clk); #1;
    check_val({tag, "_rv_e9"}, sel ? rv1 : rv0, 1);
    check_val({tag, "_digest"}, sel ? dig1 : dig0, exp_dig);
    check_val({tag, "_hit"}, sel ? hit1 : hit0, exp_hit);
    $display("txn %s: base=%h digest=%h hit=%0d", tag, base, sel ? dig1 : dig0, sel ? hit1 : hit0);
  endtask

  // With result_ready high, the handshake completes on the next edge.
  task automatic finish_op(input bit sel, input string tag);
    @(posedge clk); #1;
    check_val({tag, "_rv_done"}, sel ? rv1 : rv0, 0);
    check_val({tag, "_busy_done"}, sel ? busy1 : busy0, 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    start0       = 1'b0;
    start1       = 1'b0;
    result_ready = 1'b1;
    digest_addr  = 16'h0;
    target       = '0;
    load_digest(16'h0040, ABC);
    load_digest(16'h0100, BP);
    load_digest(16'hfffc, WRAP);
    load_digest(16'h0200, REV_MEM);

    #12;
    check_val("rst_addr", addr0, 0);
    check_val("rst_busy", busy0, 0);
    check_val("rst_rv", rv0, 0);
    check_val("rst_hit", hit0, 0);
    check_val("rst_digest", dig0, 0);
    check_val("rst_we", we0, 0);
    check_val("rst_wdata", wdata0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Basic read with an all-ones target; start held across the handshake edge.
    run_op(0, 16'h0040, ALLF, ABC, 1'b1, "abc_hit");
    @(negedge clk);
    start0      = 1'b1;
    digest_addr = 16'h0100;
    @(posedge clk); #1;
    start0 = 1'b0;
    check_val("hs_rv", rv0, 0);
    check_val("hs_busy", busy0, 0);
    @(posedge clk); #1;
    check_val("hs_start_ignored_busy", busy0, 0);
    check_val("hs_start_ignored_addr", addr0, 16'h0047);

    // Boundary compares on the same digest.
    run_op(0, 16'h0040, ABC, ABC, 1'b0, "eq_target");
    finish_op(0, "eq_target");
    run_op(0, 16'h0040, ABC + 256'd1, ABC, 1'b1, "plus_one");
    finish_op(0, "plus_one");
    run_op(0, 16'h0040, {32'hba7816be, 224'h0} | {32'h0, {224{1'b1}}}, ABC, 1'b0, "w0_less");
    finish_op(0, "w0_less");

    // Backpressure: result held for 5 cycles, a start pulse is ignored.
    result_ready = 1'b0;
    run_op(0, 16'h0040, ALLF, ABC, 1'b1, "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) begin
        start0      = 1'b1;
        digest_addr = 16'h0100;
      end
      @(posedge clk); #1;
      start0 = 1'b0;
      check_val($sformatf("bp_rv%0d", c), rv0, 1);
      check_val($sformatf("bp_busy%0d", c), busy0, 1);
      check_val($sformatf("bp_dig%0d", c), dig0, ABC);
      check_val($sformatf("bp_addr%0d", c), addr0, 16'h0047);
    end
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_release_rv", rv0, 0);
    check_val("bp_release_busy", busy0, 0);
    run_op(0, 16'h0100, 256'h0, BP, 1'b0, "bp_next");
    finish_op(0, "bp_next");

    // Address wrap across 16'hFFFF.
    run_op(0, 16'hfffc, ALLF, WRAP, 1'b1, "wrap");
    finish_op(0, "wrap");

    // Reset after word 4 is captured (edge E6).
    @(negedge clk);
    digest_addr = 16'h0040;
    target      = ALLF;
    start0      = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_addr", addr0, 0);
    check_val("mid_rst_busy", busy0, 0);
    check_val("mid_rst_rv", rv0, 0);
    check_val("mid_rst_digest", dig0, 0);
    check_val("mid_rst_hit", hit0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op(0, 16'h0040, ALLF, ABC, 1'b1, "after_rst");
    finish_op(0, "after_rst");

    // Byte-reversing instance.
    run_op(1, 16'h0200, T_2_240, REV_EXP, 1'b0, "rev_miss");
    finish_op(1, "rev_miss");
    run_op(1, 16'h0200, ALLF, REV_EXP, 1'b1, "rev_hit");
    finish_op(1, "rev_hit");
    check_val("we_never", {we0, we1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
